// File: rtl/ulvds_txbus_arbiter_if.sv
// rtl/ulvds_txbus_arbiter_if.sv - requester/pad-drive signal bundle for ulvds_txbus_arbiter
// slave modport faces the arbiter, master modport faces requesters and pad logic.
interface ulvds_txbus_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic                    GTS;
   logic [NREQ-1:0]         REQ;
   logic [NREQ*WIDTH-1:0]   DATA;
   logic [NREQ-1:0]         GNT;
   logic [NREQ-1:0]         ACK;
   logic                    TXD;
   logic                    TXT;
   logic                    BUSY;

   modport slave  (input  GTS, REQ, DATA, output GNT, ACK, TXD, TXT, BUSY);
   modport master (output GTS, REQ, DATA, input  GNT, ACK, TXD, TXT, BUSY);
endinterface

// File: rtl/ulvds_txbus_arbiter.sv
// rtl/ulvds_txbus_arbiter.sv - round-robin arbiter and LSB-first serialiser for a shared tri-state diff pair
// Optional trailing even-parity bit is enabled by defining ULVDS_TXBUS_PARITY_EN.
module ulvds_txbus_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int LEAD  = 1,
   parameter int TURN  = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   ulvds_txbus_arbiter_if.slave  bus
);

`ifdef ULVDS_TXBUS_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = $clog2(NBITS + LEAD + TURN + 1);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TURN} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sh_q;
   logic             par_q;
   logic [PW-1:0]    ptr_q;
   logic [PW-1:0]    win_q;
   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  ack_q;
   logic             txd_q;
   logic             txt_q;
   logic             busy_q;

   logic             found;
   logic [PW-1:0]    pick;
   logic [WIDTH-1:0] pick_data;
   logic [PW-1:0]    ptr_d;

   // First requesting index at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = ptr_q;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && bus.REQ[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
      pick_data = bus.DATA[int'(pick)*WIDTH +: WIDTH];
      ptr_d     = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         ptr_q   <= '0;
         win_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         txd_q   <= 1'b0;
         txt_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         ack_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (!bus.GTS && found) begin
                  win_q  <= pick;
                  gnt_q  <= NREQ'(1) << pick;
                  txt_q  <= 1'b0;
                  busy_q <= 1'b1;
                  par_q  <= ^pick_data;
                  cnt_q  <= '0;
                  if (LEAD > 0) begin
                     state_q <= S_LEAD;
                     txd_q   <= 1'b1;
                     sh_q    <= pick_data;
                  end else begin
                     state_q <= S_SHIFT;
                     txd_q   <= pick_data[0];
                     sh_q    <= pick_data >> 1;
                  end
               end
            end
            S_LEAD, S_SHIFT: begin
               if (bus.GTS) begin
                  // Abort: release the pads, no ACK, but still rotate past the winner.
                  state_q <= S_TURN;
                  cnt_q   <= '0;
                  txt_q   <= 1'b1;
                  txd_q   <= 1'b0;
                  gnt_q   <= '0;
                  ptr_q   <= ptr_d;
               end else if (state_q == S_LEAD) begin
                  if (cnt_q == CW'(LEAD-1)) begin
                     state_q <= S_SHIFT;
                     cnt_q   <= '0;
                     txd_q   <= sh_q[0];
                     sh_q    <= sh_q >> 1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (cnt_q == CW'(NBITS-1)) begin
                  state_q <= S_TURN;
                  cnt_q   <= '0;
                  txt_q   <= 1'b1;
                  txd_q   <= 1'b0;
                  gnt_q   <= '0;
                  ack_q   <= gnt_q;
                  ptr_q   <= ptr_d;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  sh_q  <= sh_q >> 1;
                  txd_q <= (cnt_q == CW'(WIDTH-1)) ? par_q : sh_q[0];
               end
            end
            S_TURN: begin
               if (cnt_q == CW'(TURN-1)) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.ACK  = ack_q;
   assign bus.TXD  = txd_q;
   assign bus.TXT  = txt_q;
   assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_ulvds_txbus_arbiter.sv
// tb/tb_ulvds_txbus_arbiter.sv - scoreboard bench for ulvds_txbus_arbiter
// Stimulus pushes expected transfers; a monitor reassembles each TXT-low window and compares.
module tb_ulvds_txbus_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int LEAD  = 1;
   localparam int TURN  = 2;
`ifdef ULVDS_TXBUS_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FULL = LEAD + WIDTH + PAR;

   typedef struct {
      logic [NREQ-1:0]  gnt;
      logic [WIDTH-1:0] data;
      int               len;
      bit               done;
      int               gap;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t expq[$];

   ulvds_txbus_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   ulvds_txbus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LEAD(LEAD), .TURN(TURN)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] d,
                       input int len, input bit done, input int gap);
      exp_t e;
      e.gnt = g; e.data = d; e.len = len; e.done = done; e.gap = gap;
      expq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      bus.DATA[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic wait_ack(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.ACK == '0 && n < 200);
      if (bus.ACK == '0) begin
         checks++;
         errors++;
         $display("FAIL %s: got no ACK expected ACK within 200 cycles", name);
      end
   endtask

   task automatic wait_txt_low(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.TXT !== 1'b0 && n < 200);
      if (bus.TXT !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s: got TXT=1 expected TXT=0 within 200 cycles", name);
      end
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_txt", bus.TXT, 1);
      chk("rst_txd", bus.TXD, 0);
      chk("rst_gnt", bus.GNT, 0);
      chk("rst_ack", bus.ACK, 0);
      chk("rst_busy", bus.BUSY, 0);
      rst_n = 1'b1;
   endtask

   // Monitor: reassemble each TXT-low window and score it against the queue.
   initial begin
      bit              in_win;
      int              wlen;
      logic [NREQ-1:0] wgnt;
      logic [63:0]     wbits;
      logic [63:0]     eb;
      longint          cyc, ws_prev, ws_cur;
      exp_t            e;
      in_win = 0; wlen = 0; wgnt = '0; wbits = '0; cyc = 0; ws_prev = 0; ws_cur = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!in_win && bus.TXT === 1'b0) begin
            in_win  = 1;
            wlen    = 0;
            wbits   = '0;
            wgnt    = bus.GNT;
            ws_prev = ws_cur;
            ws_cur  = cyc;
            chk("win_busy", bus.BUSY, 1);
         end
         if (in_win && bus.TXT === 1'b0) begin
            if (wlen < 64) wbits[wlen] = bus.TXD;
            wlen++;
            if (bus.GNT !== wgnt) chk("gnt_held", bus.GNT, wgnt);
         end else if (in_win) begin
            in_win = 0;
            if (expq.size() == 0) begin
               chk("unexpected_window", wgnt, 0);
            end else begin
               e  = expq.pop_front();
               eb = '0;
               for (int i = 0; i < e.len; i++)
                  eb[i] = (i < LEAD) ? 1'b1 : ((i - LEAD < WIDTH) ? e.data[i-LEAD] : ^e.data);
               chk("win_gnt", wgnt, e.gnt);
               chk("win_len", wlen, e.len);
               chk("win_txd", wbits, eb);
               chk("win_ack", bus.ACK, e.done ? e.gnt : '0);
               chk("turn_gnt", bus.GNT, 0);
               if (e.gap != 0) chk("win_gap", ws_cur - ws_prev, e.gap);
            end
         end else if (bus.ACK !== '0) begin
            chk("stray_ack", bus.ACK, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.GTS = 1'b0;
      bus.REQ = '0;
      bus.DATA = '0;
      do_reset();

      // Single transfer, DATA changed after arbitration must not matter.
      set_data(0, 8'hA5);
      bus.REQ = 4'b0001;
      push(4'b0001, 8'hA5, FULL, 1, 0);
      tick();
      chk("t1_gnt", bus.GNT, 4'b0001);
      chk("t1_txt", bus.TXT, 0);
      set_data(0, 8'h00);
      wait_ack("t1_ack");
      bus.REQ = '0;
      repeat (3) tick();
      chk("t1_busy_after", bus.BUSY, 0);

      // Round-robin from pointer 0 with all requesting.
      do_reset();
      set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h3C); set_data(3, 8'hC4);
      bus.REQ = 4'b1111;
      push(4'b0001, 8'h11, FULL, 1, 0);
      push(4'b0010, 8'h22, FULL, 1, 1 + FULL + TURN);
      push(4'b0100, 8'h3C, FULL, 1, 1 + FULL + TURN);
      push(4'b1000, 8'hC4, FULL, 1, 1 + FULL + TURN);
      push(4'b0001, 8'h11, FULL, 1, 1 + FULL + TURN);
      repeat (5) wait_ack("t2_ack");
      bus.REQ = '0;
      repeat (4) tick();

      // Pointer 1: serve 1, then 4'b1011 gives 3 then 0.
      bus.REQ = 4'b0010;
      push(4'b0010, 8'h22, FULL, 1, 0);
      wait_ack("t3a_ack");
      bus.REQ = '0;
      repeat (4) tick();
      bus.REQ = 4'b1011;
      push(4'b1000, 8'hC4, FULL, 1, 0);
      push(4'b0001, 8'h11, FULL, 1, 1 + FULL + TURN);
      repeat (2) wait_ack("t3b_ack");
      bus.REQ = '0;
      repeat (4) tick();

      // GTS abort during 4th data bit of requester 2; 0 then 2 follow.
      bus.REQ = 4'b0101;
      push(4'b0100, 8'h3C, LEAD + 4, 0, 0);
      push(4'b0001, 8'h11, FULL, 1, LEAD + 4 + TURN + 1);
      push(4'b0100, 8'h3C, FULL, 1, 1 + FULL + TURN);
      wait_txt_low("t4_start");
      repeat (LEAD + 3) tick();
      bus.GTS = 1'b1;
      tick();
      bus.GTS = 1'b0;
      chk("t4_abort_txt", bus.TXT, 1);
      chk("t4_abort_gnt", bus.GNT, 0);
      repeat (2) wait_ack("t4_ack");
      bus.REQ = '0;
      repeat (4) tick();

      // GTS held in IDLE blocks the grant.
      bus.GTS = 1'b1;
      bus.REQ = 4'b0001;
      repeat (6) tick();
      chk("t5_gts_txt", bus.TXT, 1);
      chk("t5_gts_busy", bus.BUSY, 0);
      chk("t5_gts_gnt", bus.GNT, 0);
      push(4'b0001, 8'h11, FULL, 1, 0);
      bus.GTS = 1'b0;
      wait_ack("t5_ack");
      bus.REQ = '0;
      repeat (4) tick();

      // Async reset mid-SHIFT of requester 2.
      bus.REQ = 4'b0100;
      push(4'b0100, 8'h3C, LEAD + 2, 0, 0);
      wait_txt_low("t6_start");
      repeat (LEAD + 1) tick();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      bus.REQ = '0;
      #1;
      chk("t6_async_txt", bus.TXT, 1);
      chk("t6_async_gnt", bus.GNT, 0);
      chk("t6_async_busy", bus.BUSY, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      bus.REQ = 4'b0011;
      push(4'b0001, 8'h11, FULL, 1, 0);
      wait_ack("t6_ack");
      bus.REQ = '0;
      repeat (4) tick();

      // Parity case (parity of 8'h07 is 1).
      set_data(2, 8'h07);
      bus.REQ = 4'b0100;
      push(4'b0100, 8'h07, FULL, 1, 0);
      wait_ack("t7_ack");
      bus.REQ = '0;
      repeat (5) tick();
      chk("t7_busy_after", bus.BUSY, 0);
      chk("queue_drained", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
